// File: rtl/sram_rw_bytemask.sv
// sram_rw_bytemask
// Single-port read/write SRAM behavioural model with active-low csb0/web0,
// per-byte write mask, a read latency of 1 or 2 with a read-valid strobe,
// and an optional post-reset clear sequence that zeroes every word before
// any request is accepted.
module sram_rw_bytemask #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1,
  localparam int NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH,
  localparam int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_BYTES-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  output logic                  busy0
);

  // Reject configurations the lane slicing and output pipeline cannot honour.
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $fatal(1, "sram_rw_bytemask: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $fatal(1, "sram_rw_bytemask: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic                  CLEAR_ON = (INIT_CLEAR != 0);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  clr_en;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;

  // rst_n gating keeps the array untouched while reset is held.
  assign clr_en = rst_n & (state == ST_CLEAR);
  assign accept = rst_n & (state == ST_READY) & ~csb0;
  assign wr_en  = accept & ~web0;
  assign rd_en  = accept & web0;
  assign mem_rd = mem[addr0];

  // Clear sequencer: walks cnt over every word once, then opens the port.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON ? ST_CLEAR : ST_READY;
      cnt   <= '0;
      busy0 <= CLEAR_ON;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (cnt == CNT_LAST) begin
            state <= ST_READY;
            busy0 <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1'b1);
          end
        end
        ST_READY: begin
          busy0 <= 1'b0;
        end
        default: begin
          state <= ST_READY;
          busy0 <= 1'b0;
        end
      endcase
    end
  end

  // Array update: clear writes take priority; normal writes merge enabled lanes.
  always_ff @(posedge clk0) begin
    if (clr_en) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*BYTE_WIDTH +: BYTE_WIDTH] <= din0[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    // Single-stage read: data and strobe registered at the accepting edge.
    always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
        dout0   <= '0;
        rvalid0 <= 1'b0;
      end else begin
        rvalid0 <= rd_en;
        if (rd_en) begin
          dout0 <= mem_rd;
        end
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_vld;

    // Two-stage read: intermediate register then output register.
    always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
        rd_data <= '0;
        rd_vld  <= 1'b0;
        dout0   <= '0;
        rvalid0 <= 1'b0;
      end else begin
        rd_vld  <= rd_en;
        rvalid0 <= rd_vld;
        if (rd_en) begin
          rd_data <= mem_rd;
        end
        if (rd_vld) begin
          dout0 <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_rw_bytemask.sv
// tb_sram_rw_bytemask
// Directed bench: three instances share the request bus -- latency 1 with
// clear, latency 2 with clear, and latency 1 without clear (own csb/reset).
module tb_sram_rw_bytemask;

  logic        clk0 = 1'b0;
  logic        rst_n, rst_nc;
  logic        csb0, csb_nc, web0;
  logic [3:0]  wmask0;
  logic [9:0]  addr0;
  logic [31:0] din0;

  logic [31:0] dout_l1, dout_l2, dout_nc;
  logic        rvalid_l1, rvalid_l2, rvalid_nc;
  logic        busy_l1, busy_l2, busy_nc;

  int n_total = 0;
  int n_pass  = 0;

  logic        rv1, rv2;
  logic [31:0] rd1, rd2;
  logic [6:0]  vmask1, vmask2;
  logic [31:0] bd1 [7];
  logic [31:0] bd2 [7];
  int          nb1, nb2;
  bit          saw_rv;

  always #5 clk0 = ~clk0;

  sram_rw_bytemask #(.READ_LATENCY(1), .INIT_CLEAR(1)) u_l1 (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout_l1), .rvalid0(rvalid_l1), .busy0(busy_l1)
  );

  sram_rw_bytemask #(.READ_LATENCY(2), .INIT_CLEAR(1)) u_l2 (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout_l2), .rvalid0(rvalid_l2), .busy0(busy_l2)
  );

  sram_rw_bytemask #(.READ_LATENCY(1), .INIT_CLEAR(0)) u_nc (
    .clk0(clk0), .rst_n(rst_nc), .csb0(csb_nc), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout_nc), .rvalid0(rvalid_nc), .busy0(busy_nc)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one write, returns at the next negedge.
  task automatic write1(input logic [3:0] m, input logic [9:0] a, input logic [31:0] d);
    csb0 = 1'b0; web0 = 1'b0; wmask0 = m; addr0 = a; din0 = d;
    @(negedge clk0);
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'b0000;
  endtask

  // Issues one read; captures latency-1 result one negedge later and
  // latency-2 result two negedges later.
  task automatic read1(input logic [9:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
    @(negedge clk0);
    rv1 = rvalid_l1; rd1 = dout_l1;
    csb0 = 1'b1;
    @(negedge clk0);
    rv2 = rvalid_l2; rd2 = dout_l2;
  endtask

  // Counts busy cycles from the release negedge (bounded); optionally drives
  // a write into the clear window at its 10th cycle.
  task automatic count_busy(input bit inject, output int n1, output int n2, output bit saw);
    n1 = 0; n2 = 0; saw = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (busy_l1) n1++;
      if (busy_l2) n2++;
      if (rvalid_l1 || rvalid_l2) saw = 1'b1;
      if (inject && cyc == 10) begin
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 10'd0; din0 = 32'hFFFF_FFFF;
      end else begin
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'b0000;
      end
      if (!busy_l1 && !busy_l2) break;
      @(negedge clk0);
    end
    csb0 = 1'b1; web0 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst_nc = 1'b0;
    csb0 = 1'b1; csb_nc = 1'b1; web0 = 1'b1;
    wmask0 = 4'b0000; addr0 = 10'd0; din0 = 32'h0000_0000;
    repeat (3) @(negedge clk0);

    // Reset state
    check_value("rst_dout",   dout_l1,   32'h0);
    check_value("rst_rvalid", {31'h0, rvalid_l1}, 32'h0);
    check_value("rst_busy1",  {31'h0, busy_l1},   32'h1);
    check_value("rst_busy2",  {31'h0, busy_l2},   32'h1);
    check_value("rst_busy_nc", {31'h0, busy_nc},  32'h0);

    // Clear window, with a write driven into clear cycle 10
    rst_n = 1'b1; rst_nc = 1'b1;
    count_busy(1'b1, nb1, nb2, saw_rv);
    check_value("clear_len_l1", nb1, 32'd1024);
    check_value("clear_len_l2", nb2, 32'd1024);
    check_value("clear_no_rvalid", {31'h0, saw_rv}, 32'h0);

    // First read after clear
    read1(10'd5);
    check_value("rd5_vld_l1", {31'h0, rv1}, 32'h1);
    check_value("rd5_dat_l1", rd1, 32'h0);
    check_value("rd5_vld_l2", {31'h0, rv2}, 32'h1);
    check_value("rd5_dat_l2", rd2, 32'h0);

    // Write issued during clear must have been dropped
    read1(10'd0);
    check_value("busy_drop_l1", rd1, 32'h0);
    check_value("busy_drop_l2", rd2, 32'h0);

    // Byte-mask merge, read-after-write on the next cycle
    write1(4'b1111, 10'd3, 32'hDEAD_BEEF);
    write1(4'b0101, 10'd3, 32'h1122_3344);
    read1(10'd3);
    check_value("merge_l1", rd1, 32'hDE22_BE44);
    check_value("merge_l2", rd2, 32'hDE22_BE44);
    write1(4'b0000, 10'd3, 32'hFFFF_FFFF);
    check_value("wr_no_rvalid", {31'h0, rvalid_l1}, 32'h0);
    check_value("wr_dout_hold", dout_l1, 32'hDE22_BE44);
    read1(10'd3);
    check_value("mask0_noop", rd1, 32'hDE22_BE44);

    // Top address
    write1(4'b1111, 10'd1023, 32'h1234_5678);
    read1(10'd1023);
    check_value("top_addr_l1", rd1, 32'h1234_5678);
    check_value("top_addr_l2", rd2, 32'h1234_5678);
    read1(10'd0);
    check_value("addr0_untouched", rd1, 32'h0);

    // Back-to-back read burst
    for (int i = 0; i < 4; i++) write1(4'b1111, 10'(i), 32'hA0 + 32'(i));
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        csb0 = 1'b0; web0 = 1'b1; addr0 = 10'(k);
      end else begin
        csb0 = 1'b1;
      end
      @(negedge clk0);
      vmask1[k] = rvalid_l1; bd1[k] = dout_l1;
      vmask2[k] = rvalid_l2; bd2[k] = dout_l2;
    end
    check_value("burst_vld_l1", {25'h0, vmask1}, {25'h0, 7'b0001111});
    check_value("burst_vld_l2", {25'h0, vmask2}, {25'h0, 7'b0011110});
    for (int k = 0; k < 4; k++) begin
      check_value($sformatf("burst_l1_%0d", k), bd1[k],   32'hA0 + 32'(k));
      check_value($sformatf("burst_l2_%0d", k), bd2[k+1], 32'hA0 + 32'(k));
    end
    check_value("burst_hold_l1", bd1[6], 32'hA3);
    check_value("burst_hold_l2", bd2[6], 32'hA3);

    // Reset with a latency-2 read in flight
    csb0 = 1'b0; web0 = 1'b1; addr0 = 10'd1;
    @(posedge clk0);
    #2 rst_n = 1'b0;
    #1;
    check_value("mid_rst_dout_l2",   dout_l2, 32'h0);
    check_value("mid_rst_rvalid_l2", {31'h0, rvalid_l2}, 32'h0);
    check_value("mid_rst_dout_l1",   dout_l1, 32'h0);
    csb0 = 1'b1;
    repeat (2) @(negedge clk0);
    rst_n = 1'b1;
    count_busy(1'b0, nb1, nb2, saw_rv);
    check_value("reclear_len_l2", nb2, 32'd1024);
    check_value("reclear_no_rvalid", {31'h0, saw_rv}, 32'h0);
    read1(10'd1);
    check_value("reclear_data_l2", rd2, 32'h0);

    // No-clear instance: data survives reset, busy never rises
    csb_nc = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 10'd7; din0 = 32'hCAFE_F00D;
    @(negedge clk0);
    csb_nc = 1'b1; web0 = 1'b1;
    rst_nc = 1'b0;
    #1;
    check_value("nc_rst_busy", {31'h0, busy_nc}, 32'h0);
    @(negedge clk0);
    rst_nc = 1'b1;
    @(negedge clk0);
    check_value("nc_post_busy", {31'h0, busy_nc}, 32'h0);
    csb_nc = 1'b0; web0 = 1'b1; addr0 = 10'd7;
    @(negedge clk0);
    check_value("nc_rd_vld", {31'h0, rvalid_nc}, 32'h1);
    check_value("nc_rd_dat", dout_nc, 32'hCAFE_F00D);
    csb_nc = 1'b1;
    @(negedge clk0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
